// File: rtl/md_unit_if.sv
// md_unit_if: execute-stage port bundle for the multiply/divide unit.
// Carries decoder flags, operands, HI/LO views and the stall request.
interface md_unit_if;
    logic        en;
    logic        mult;
    logic        multu;
    logic        div;
    logic        divu;
    logic        madd;
    logic        maddu;
    logic        msub;
    logic        msubu;
    logic        mfhi;
    logic        mflo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;
    logic        busy;
    logic        stall;

    modport master (
        output en, mult, multu, div, divu, madd, maddu, msub, msubu,
        output mfhi, mflo, mthi, mtlo, a, b,
        input  hi, lo, md_out, busy, stall
    );

    modport slave (
        input  en, mult, multu, div, divu, madd, maddu, msub, msubu,
        input  mfhi, mflo, mthi, mtlo, a, b,
        output hi, lo, md_out, busy, stall
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div/madd/msub engine owning HI/LO.
// Results land at the edge busy falls; stall holds dependent ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset_n,
    md_unit_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
        OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
    } op_t;

    localparam logic [3:0] MUL_L = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_L = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        start_v;
    op_t         start_op;
    logic        sgn;
    logic [63:0] a_ext, b_ext, prod, acc;
    logic [31:0] abs_a, abs_b, quo_u, rem_u, quo, rem;

    // Decode the one-hot start flags into an operation code.
    always_comb begin
        start_v  = 1'b1;
        start_op = OP_MULT;
        case (1'b1)
            md.mult:  start_op = OP_MULT;
            md.multu: start_op = OP_MULTU;
            md.madd:  start_op = OP_MADD;
            md.maddu: start_op = OP_MADDU;
            md.msub:  start_op = OP_MSUB;
            md.msubu: start_op = OP_MSUBU;
            md.div:   start_op = OP_DIV;
            md.divu:  start_op = OP_DIVU;
            default:  start_v  = 1'b0;
        endcase
    end

    // Datapath on the latched operands: 64-bit product and signed-magnitude divide.
    always_comb begin
        sgn   = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                (op_q == OP_MSUB) || (op_q == OP_DIV);
        a_ext = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        b_ext = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = a_ext * b_ext;
        acc   = {hi_q, lo_q};
        abs_a = (sgn && a_q[31]) ? (32'd0 - a_q) : a_q;
        abs_b = (sgn && b_q[31]) ? (32'd0 - b_q) : b_q;
        quo_u = abs_a / abs_b;
        rem_u = abs_a % abs_b;
        quo   = (sgn && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_u) : quo_u;
        rem   = (sgn && a_q[31]) ? (32'd0 - rem_u) : rem_u;
    end

    // Next-state: accept in IDLE, count down in RUN, write HI/LO on the last cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (md.en) begin
                    if (start_v) begin
                        op_d    = start_op;
                        a_d     = md.a;
                        b_d     = md.b;
                        state_d = RUN;
                        cnt_d   = (start_op == OP_DIV || start_op == OP_DIVU)
                                  ? DIV_L : MUL_L;
                    end else if (md.mthi) begin
                        hi_d = md.a;
                    end else if (md.mtlo) begin
                        lo_d = md.a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    case (op_q)
                        OP_MULT, OP_MULTU:   {hi_d, lo_d} = prod;
                        OP_MADD, OP_MADDU:   {hi_d, lo_d} = acc + prod;
                        OP_MSUB, OP_MSUBU:   {hi_d, lo_d} = acc - prod;
                        default: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and HI/LO registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
    assign md.busy   = (state_q == RUN);
    assign md.md_out = md.mfhi ? hi_q : lo_q;
    assign md.stall  = md.en & md.busy &
                       (md.mult | md.multu | md.div | md.divu |
                        md.madd | md.maddu | md.msub | md.msubu |
                        md.mfhi | md.mflo | md.mthi | md.mtlo);
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit.
// Expected values are hand-computed constants.
module tb_md_unit;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.en    = 1'b0;
    bus.mult  = 1'b0;
    bus.multu = 1'b0;
    bus.div   = 1'b0;
    bus.divu  = 1'b0;
    bus.madd  = 1'b0;
    bus.maddu = 1'b0;
    bus.msub  = 1'b0;
    bus.msubu = 1'b0;
    bus.mfhi  = 1'b0;
    bus.mflo  = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  task automatic set_op(input int which);
    clr();
    bus.en = 1'b1;
    case (which)
      0: bus.mult  = 1'b1;
      1: bus.multu = 1'b1;
      2: bus.madd  = 1'b1;
      3: bus.maddu = 1'b1;
      4: bus.msub  = 1'b1;
      5: bus.msubu = 1'b1;
      6: bus.div   = 1'b1;
      default: bus.divu = 1'b1;
    endcase
  endtask

  task automatic run_op(
    input  int          which,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    output int          n
  );
    set_op(which);
    bus.a = av;
    bus.b = bv;
    tick();
    clr();
    bus.a = 32'h1234_5678;
    bus.b = 32'h9ABC_DEF0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      k++;
      tick();
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    bus.a   = 32'd0;
    bus.b   = 32'd0;
    reset_n = 1'b0;
    #2;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;

    run_op(0, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_cycles", cyc, 5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    run_op(1, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    clr();
    bus.en   = 1'b1;
    bus.mthi = 1'b1;
    bus.a    = 32'd0;
    tick();
    chk("mthi_busy", bus.busy, 1'b0);
    chk("mthi_hi", bus.hi, 32'h0);
    clr();
    bus.en   = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'h10;
    tick();
    clr();
    chk("mtlo_lo", bus.lo, 32'h10);

    run_op(2, 32'd4, 32'd5, cyc);
    chk("madd_cycles", cyc, 5);
    chk("madd_lo", bus.lo, 32'h24);
    chk("madd_hi", bus.hi, 32'h0);

    run_op(5, 32'h25, 32'd1, cyc);
    chk("msubu_hi", bus.hi, 32'hFFFF_FFFF);
    chk("msubu_lo", bus.lo, 32'hFFFF_FFFF);

    run_op(6, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_cycles", cyc, 10);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(6, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    run_op(7, 32'd77, 32'd0, cyc);
    chk("divz_cycles", cyc, 10);
    chk("divz_lo", bus.lo, 32'h8000_0000);
    chk("divz_hi", bus.hi, 32'h0);

    set_op(0);
    bus.a = 32'd3;
    bus.b = 32'd7;
    tick();
    clr();
    bus.en   = 1'b1;
    bus.mflo = 1'b1;
    cyc = 0;
    while (bus.stall && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("stall_cycles", cyc, 5);
    chk("stall_low", bus.stall, 1'b0);
    chk("mflo_out", bus.md_out, 32'd21);
    clr();

    set_op(0);
    bus.a = 32'd2;
    bus.b = 32'd2;
    tick();
    bus.a = 32'd9;
    bus.b = 32'd9;
    chk("run_stall", bus.stall, 1'b1);
    tick();
    clr();
    wait_idle();
    chk("ignore_lo", bus.lo, 32'd4);
    chk("ignore_hi", bus.hi, 32'd0);
    tick();
    chk("ignore_busy", bus.busy, 1'b0);
    bus.en   = 1'b1;
    bus.mfhi = 1'b1;
    #1;
    chk("mfhi_out", bus.md_out, 32'd0);
    clr();

    run_op(1, 32'd5, 32'd6, cyc);
    set_op(6);
    bus.a = 32'd100;
    bus.b = 32'd7;
    tick();
    clr();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    chk("arst_busy", bus.busy, 1'b0);
    tick();
    #3;
    reset_n = 1'b1;
    tick();
    tick();
    chk("arst_keep_lo", bus.lo, 32'h0);
    clr();
    bus.en   = 1'b1;
    bus.mthi = 1'b1;
    bus.a    = 32'hA5A5_A5A5;
    tick();
    clr();
    chk("post_mthi_hi", bus.hi, 32'hA5A5_A5A5);
    chk("post_mthi_busy", bus.busy, 1'b0);
    tick();
    chk("post_busy_2", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
